// File: rtl/piso_serializer.sv
// Purpose : parallel-in, serial-out shifter, LSB first, feeding a downstream SIPO
//           (serial_out -> serial_in, serial_valid -> shift).
// Latency : bit 0 on serial_out the cycle after a word is accepted; back-to-back
//           words stream with no idle cycle between frames.
// Backpressure: shift_en=0 freezes the frame and drops serial_valid; load_ready
//           is only offered in IDLE or on an enabled final cycle.
// Build option: define PISO_PARITY_EN to append one even-parity bit per frame.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
`ifdef PISO_PARITY_EN
  // Parity is computed once at load so it survives the shifting of shreg.
  logic             par_q;
`endif

  logic busy;
  logic last_bit;
  logic final_cyc;
  logic accept;
  logic advance;

  assign busy     = (state != ST_IDLE);
  assign last_bit = (state == ST_SHIFT) && (cnt == CNT_LAST);

`ifdef PISO_PARITY_EN
  // The parity beat closes the frame, so it owns done and the reload slot.
  assign final_cyc = (state == ST_PARITY);
`else
  assign final_cyc = last_bit;
`endif

  // A new word can only land where it does not overwrite undelivered bits.
  assign load_ready   = !clr && (!busy || (final_cyc && shift_en));
  assign accept       = load_valid && load_ready;
  assign serial_valid = busy && shift_en && !clr;
  assign advance      = serial_valid;
  assign done         = serial_valid && final_cyc;

  // serial_out is held at 0 in IDLE so the line is quiet between frames.
  always_comb begin
    serial_out = 1'b0;
    case (state)
      ST_SHIFT:  serial_out = shreg[0];
`ifdef PISO_PARITY_EN
      ST_PARITY: serial_out = par_q;
`endif
      default:   serial_out = 1'b0;
    endcase
  end

  // Frame state machine: load, shift one bit per enabled cycle, then idle or reload.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (accept) begin
      // Covers both a fresh start from IDLE and a back-to-back reload.
      state <= ST_SHIFT;
      shreg <= din;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par_q <= ^din;
`endif
    end else if (advance) begin
      case (state)
        ST_SHIFT: begin
          if (last_bit) begin
`ifdef PISO_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_IDLE;
`endif
            shreg <= '0;
            cnt   <= '0;
          end else begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt   <= cnt + CNT_ONE;
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          state <= ST_IDLE;
          par_q <= 1'b0;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-based model of pending serial bits checked
// every cycle, plus literal per-scenario expectations and an attached 4-bit SIPO.
// Works with or without PISO_PARITY_EN defined.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] din;
  logic       load_valid;
  logic       load_ready;
  logic       shift_en;
  logic       serial_out;
  logic       serial_valid;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  piso_serializer #(.WIDTH(4)) dut (
    .clk          (clk),
    .clr          (clr),
    .din          (din),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the bits still owed on the wire, front = the one presented now.
  logic exp_q[$];
  int   n_acc = 0;

  function automatic logic model_ready();
    return !clr && (exp_q.size() == 0 || (exp_q.size() == 1 && shift_en));
  endfunction

  always @(posedge clk) begin
    logic acc;
    acc = load_valid && model_ready();
    if (clr) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && shift_en) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(din[i]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^din);
`endif
        n_acc++;
      end
    end
  end

  // Downstream SIPO: shifts in MSB side so LSB-first data lands in order.
  logic [3:0] sipo_q;
  always @(posedge clk) begin
    if (clr) sipo_q <= 4'h0;
    else if (serial_valid) sipo_q <= {serial_out, sipo_q[3:1]};
  end

  // Record of every consumed bit and whether it carried done.
  logic seen[$];
  logic seen_done[$];

  // Per-cycle compare of all outputs against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic ev;
      ev = (exp_q.size() > 0) && shift_en && !clr;
      chk("load_ready",   {31'd0, load_ready},   {31'd0, model_ready()});
      chk("serial_valid", {31'd0, serial_valid}, {31'd0, ev});
      chk("done",         {31'd0, done},         {31'd0, ev && exp_q.size() == 1});
      chk("serial_out",   {31'd0, serial_out},
          {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b0});
      if (serial_valid) begin
        seen.push_back(serial_out);
        seen_done.push_back(done);
      end
    end
  end

  function automatic logic [15:0] pack(input int from, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[14:0], seen[from + i]};
    return r;
  endfunction

  function automatic int done_pos(input int from);
    for (int i = from; i < seen_done.size(); i++)
      if (seen_done[i]) return i - from + 1;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] w);
    din        = w;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

`ifdef PISO_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  int base;

  initial begin
    clr = 1'b1; din = 4'h0; load_valid = 1'b0; shift_en = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    clr = 1'b0;

    // 1: reset state
    @(negedge clk);
    chk("rst_serial_valid", {31'd0, serial_valid}, 32'd0);
    chk("rst_done",         {31'd0, done},         32'd0);
    chk("rst_serial_out",   {31'd0, serial_out},   32'd0);
    chk("rst_load_ready",   {31'd0, load_ready},   32'd1);

    // 2: single word 1011 -> bits 1,1,0,1 (+ parity 1)
    base = seen.size();
    load(4'b1011);
    wait_idle("t2");
`ifdef PISO_PARITY_EN
    chk("t2_bits", {16'd0, pack(base, FL)}, 32'b11011);
    chk("t2_sipo", {28'd0, sipo_q}, 32'b1101);
`else
    chk("t2_bits", {16'd0, pack(base, FL)}, 32'b1101);
    chk("t2_sipo", {28'd0, sipo_q}, 32'b1011);
`endif
    chk("t2_done_pos", done_pos(base), FL);

    // 3: A then 5 back-to-back with load_valid held
    base = seen.size();
    din = 4'hA; load_valid = 1'b1; shift_en = 1'b1;
    step();
    din = 4'h5;
    begin
      int target;
      target = n_acc + 1;
      for (int i = 0; i < 20 && n_acc < target; i++) step();
      if (n_acc < target) chk("t3_second_accept_timeout", 32'd1, 32'd0);
    end
    load_valid = 1'b0;
    wait_idle("t3");
    chk("t3_count", seen.size() - base, 2 * FL);
`ifdef PISO_PARITY_EN
    chk("t3_bits", {16'd0, pack(base, 2 * FL)}, 32'b0101010100);
`else
    chk("t3_bits", {16'd0, pack(base, 2 * FL)}, 32'b01011010);
`endif

    // 4: pause three cycles after bit 1 of 0110
    base = seen.size();
    load(4'b0110);
    step();
    step();
    shift_en = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t4_pause_out",   {31'd0, serial_out},   32'd1);
    chk("t4_pause_valid", {31'd0, serial_valid}, 32'd0);
    chk("t4_pause_ready", {31'd0, load_ready},   32'd0);
    step();
    shift_en = 1'b1;
    wait_idle("t4");
    chk("t4_count", seen.size() - base, FL);
`ifdef PISO_PARITY_EN
    chk("t4_bits", {16'd0, pack(base, FL)}, 32'b01100);
`else
    chk("t4_bits", {16'd0, pack(base, FL)}, 32'b0110);
`endif

    // 5: clr in the middle of F, then 3
    base = seen.size();
    load(4'hF);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("t5_abort_valid", {31'd0, serial_valid}, 32'd0);
    chk("t5_abort_ready", {31'd0, load_ready},   32'd1);
    chk("t5_partial",     seen.size() - base,    2);
    base = seen.size();
    step();
    load(4'h3);
    wait_idle("t5");
`ifdef PISO_PARITY_EN
    chk("t5_bits", {16'd0, pack(base, FL)}, 32'b11000);
`else
    chk("t5_bits", {16'd0, pack(base, FL)}, 32'b1100);
`endif

    // 6: 0111 -> 1,1,1,0 (+ parity 1, done on 5th)
    base = seen.size();
    load(4'b0111);
    wait_idle("t6");
`ifdef PISO_PARITY_EN
    chk("t6_bits", {16'd0, pack(base, FL)}, 32'b11101);
`else
    chk("t6_bits", {16'd0, pack(base, FL)}, 32'b1110);
`endif
    chk("t6_done_pos", done_pos(base), FL);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
